// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the I/D memory-port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_I    = 2'd1,
      OWN_D    = 2'd2
   } owner_e;

   localparam int unsigned STARVE_MAX_DEF = 4;
   localparam int unsigned STARVE_W       = $clog2(STARVE_MAX_DEF + 1);

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of core-side request/response and memory-side signals around the arbiter.
interface mem_port_arbiter_if #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
);
   logic              i_ireq;
   logic [AW-1:0]     i_iaddr;
   logic              o_igrant;
   logic              o_irvalid;
   logic [DW-1:0]     o_irdata;
   logic              i_dreq;
   logic              i_dwe;
   logic [AW-1:0]     i_daddr;
   logic [DW-1:0]     i_dwdata;
   logic [DW/8-1:0]   i_dbe;
   logic              o_dgrant;
   logic              o_drvalid;
   logic [DW-1:0]     o_drdata;
   logic              o_mreq;
   logic              o_mwe;
   logic [AW-1:0]     o_maddr;
   logic [DW-1:0]     o_mwdata;
   logic [DW/8-1:0]   o_mbe;
   logic [DW-1:0]     i_mrdata;

   modport slave (
      input  i_ireq, i_iaddr, i_dreq, i_dwe, i_daddr, i_dwdata, i_dbe, i_mrdata,
      output o_igrant, o_irvalid, o_irdata, o_dgrant, o_drvalid, o_drdata,
      output o_mreq, o_mwe, o_maddr, o_mwdata, o_mbe
   );

   modport master (
      output i_ireq, i_iaddr, i_dreq, i_dwe, i_daddr, i_dwdata, i_dbe, i_mrdata,
      input  o_igrant, o_irvalid, o_irdata, o_dgrant, o_drvalid, o_drdata,
      input  o_mreq, o_mwe, o_maddr, o_mwdata, o_mbe
   );
endinterface

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Counts consecutive denied fetch cycles and forces a fetch grant once the limit is reached.
module arb_starve_ctr #(
   parameter int unsigned StarveMax = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic ireq_i,
   input  logic igrant_i,
   output logic force_i_o
);
   localparam int unsigned CntW = $clog2(StarveMax + 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (!ireq_i || igrant_i) begin
         cnt_d = '0;
      end else if (cnt_q != CntW'(StarveMax)) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign force_i_o = ireq_i && (cnt_q == CntW'(StarveMax));
endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch (I) and data (D) ports, D priority.
// Define ARB_STARVE_GUARD_EN to let a starved fetch request win after STARVE_MAX denials.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned AW         = 32,
   parameter int unsigned DW         = 32,
   parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
   input logic              clk,
   input logic              rst,
   mem_port_arbiter_if.slave bus
);
   logic            force_i;
   logic            i_gnt, d_gnt;
   logic            mreq, mwe;
   logic [AW-1:0]   maddr;
   logic [DW-1:0]   mwdata;
   logic [DW/8-1:0] mbe;
   owner_e          owner_q, owner_d;

`ifdef ARB_STARVE_GUARD_EN
   arb_starve_ctr #(
      .StarveMax (STARVE_MAX)
   ) u_starve_ctr (
      .clk       (clk),
      .rst       (rst),
      .ireq_i    (bus.i_ireq),
      .igrant_i  (i_gnt),
      .force_i_o (force_i)
   );
`else
   logic unused_starve_max;
   assign unused_starve_max = ^STARVE_MAX;
   assign force_i           = 1'b0;
`endif

   always_comb begin
      i_gnt   = 1'b0;
      d_gnt   = 1'b0;
      mreq    = 1'b0;
      mwe     = 1'b0;
      maddr   = '0;
      mwdata  = '0;
      mbe     = '0;
      owner_d = OWN_NONE;
      if (!rst) begin
         if (bus.i_dreq && !force_i) begin
            d_gnt = 1'b1;
         end else if (bus.i_ireq) begin
            i_gnt = 1'b1;
         end
      end
      if (d_gnt) begin
         mreq   = 1'b1;
         mwe    = bus.i_dwe;
         maddr  = bus.i_daddr;
         mwdata = bus.i_dwdata;
         mbe    = bus.i_dbe;
         // Writes return nothing, so they leave no owner behind.
         if (!bus.i_dwe) owner_d = OWN_D;
      end else if (i_gnt) begin
         mreq    = 1'b1;
         maddr   = bus.i_iaddr;
         owner_d = OWN_I;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q <= OWN_NONE;
      end else begin
         owner_q <= owner_d;
      end
   end

   assign bus.o_igrant  = i_gnt;
   assign bus.o_dgrant  = d_gnt;
   assign bus.o_mreq    = mreq;
   assign bus.o_mwe     = mwe;
   assign bus.o_maddr   = maddr;
   assign bus.o_mwdata  = mwdata;
   assign bus.o_mbe     = mbe;

   // Gate with rst so a read outstanding at reset never produces a strobe.
   assign bus.o_irvalid = !rst && (owner_q == OWN_I);
   assign bus.o_drvalid = !rst && (owner_q == OWN_D);
   assign bus.o_irdata  = bus.o_irvalid ? bus.i_mrdata : '0;
   assign bus.o_drdata  = bus.o_drvalid ? bus.i_mrdata : '0;
endmodule
